// File: rtl/pwm_duty_slewer.sv
// -----------------------------------------------------------------------------
// pwm_duty_slewer
//
// Upstream stage of the 12-bit PWM generator. It accepts duty targets over a
// valid/ready handshake, clamps them to [DUTY_MIN, DUTY_MAX] and moves the
// registered compare value toward the stored target. Compare only changes on
// the edge that ends a period_tick cycle, so the generator sees the new value
// from count 0 and never in the middle of a period. The internal period
// counter mirrors the generator's (0..PERIOD-1) and is cleared by the same rst.
//
// Configuration macro: SLEW_LIMIT_EN
//   defined   : compare moves by at most max(step,1) per period
//   undefined : compare jumps to the target at the first period boundary after
//               an accept; step is ignored
//
// Ports:
//   clk           in   1       clock
//   rst           in   1       synchronous, active-high reset
//   target        in   WIDTH   requested duty, unsigned
//   target_valid  in   1       target present
//   target_ready  out  1       target accepted when valid & ready at a rising edge
//   step          in   STEP_W  max compare change per period (0 acts as 1)
//   compare       out  WIDTH   registered duty to the PWM generator
//   period_tick   out  1       high in the cycle where period count == PERIOD-1
//   busy          out  1       high while compare has not reached the target
// -----------------------------------------------------------------------------
module pwm_duty_slewer #(
    parameter int WIDTH    = 12,
    parameter int PERIOD   = 4096,
    parameter int STEP_W   = 8,
    parameter int DUTY_MIN = 1,
    parameter int DUTY_MAX = 4094
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  target,
    input  logic              target_valid,
    output logic              target_ready,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  compare,
    output logic              period_tick,
    output logic              busy
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  count_r;
    logic [WIDTH-1:0]  target_r;
    logic [WIDTH-1:0]  target_nxt_s;
    logic [WIDTH-1:0]  compare_nxt_s;
    logic [WIDTH-1:0]  clamped_s;
    logic [WIDTH-1:0]  stepped_s;
    logic              accept_s;

    // Limit a requested duty to the range the generator can use safely.
    function automatic logic [WIDTH-1:0] clamp_duty(input logic [WIDTH-1:0] v);
        if (v < WIDTH'(DUTY_MIN)) begin
            return WIDTH'(DUTY_MIN);
        end else if (v > WIDTH'(DUTY_MAX)) begin
            return WIDTH'(DUTY_MAX);
        end else begin
            return v;
        end
    endfunction

    // Accepts are blocked in the boundary cycle so they never collide with a compare update.
    assign period_tick  = (count_r == CNT_W'(PERIOD - 1));
    assign target_ready = ~rst & ~period_tick;
    assign accept_s     = target_valid & target_ready;
    assign clamped_s    = clamp_duty(target);
    assign busy         = (state_r == RAMP);

`ifdef SLEW_LIMIT_EN
    logic [WIDTH-1:0] step_eff_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] delta_s;
    logic             up_s;

    // Next compare for this boundary: move by min(step_eff, |target - compare|).
    always_comb begin
        step_eff_s = (step == {STEP_W{1'b0}}) ? WIDTH'(1'b1) : WIDTH'(step);
        if (target_r >= compare) begin
            up_s   = 1'b1;
            diff_s = target_r - compare;
        end else begin
            up_s   = 1'b0;
            diff_s = compare - target_r;
        end
        if (diff_s < step_eff_s) begin
            delta_s = diff_s;
        end else begin
            delta_s = step_eff_s;
        end
        if (up_s) begin
            stepped_s = compare + delta_s;
        end else begin
            stepped_s = compare - delta_s;
        end
    end
`else
    logic unused_step_s;

    // Without slew limiting the boundary update lands directly on the target.
    assign unused_step_s = ^step;
    assign stepped_s     = target_r;
`endif

    // Next-state logic: accepts retarget, boundary ticks advance compare.
    always_comb begin
        state_nxt_s   = state_r;
        target_nxt_s  = target_r;
        compare_nxt_s = compare;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    target_nxt_s = clamped_s;
                    if (clamped_s != compare) begin
                        state_nxt_s = RAMP;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RAMP: begin
                if (accept_s) begin
                    target_nxt_s = clamped_s;
                    if (clamped_s != compare) begin
                        state_nxt_s = RAMP;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (period_tick) begin
                    compare_nxt_s = stepped_s;
                    if (stepped_s == target_r) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = RAMP;
                    end
                end else begin
                    state_nxt_s = RAMP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Period counter mirroring the generator: 0..PERIOD-1, then wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (period_tick) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    // State, stored target and registered compare output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            target_r <= WIDTH'(DUTY_MIN);
            compare  <= WIDTH'(DUTY_MIN);
        end else begin
            state_r  <= state_nxt_s;
            target_r <= target_nxt_s;
            compare  <= compare_nxt_s;
        end
    end

endmodule

// File: tb/tb_pwm_duty_slewer.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_slewer
//
// Self-checking bench for pwm_duty_slewer with default parameters. A reference
// model tracks period position, stored target and compare as plain integers
// and is advanced once per clock edge; every cycle the DUT outputs are checked
// against it on the falling edge. Stimulus combines directed events (slew
// sequence, clamping at both ends, a target held across the boundary, reset
// during a ramp) with randomized targets and steps.
// -----------------------------------------------------------------------------
module tb_pwm_duty_slewer;

    localparam int PER   = 4096;
    localparam int DMIN  = 1;
    localparam int DMAX  = 4094;
    localparam int NCYC  = 16 * PER;

    logic        clk;
    logic        rst;
    logic [11:0] target;
    logic        target_valid;
    logic        target_ready;
    logic [7:0]  step;
    logic [11:0] compare;
    logic        period_tick;
    logic        busy;

    int n_vec;
    int n_err;

    // Reference model state
    int m_cnt;
    int m_cmp;
    int m_tgt;
    bit m_busy;

    pwm_duty_slewer dut (
        .clk          (clk),
        .rst          (rst),
        .target       (target),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .step         (step),
        .compare      (compare),
        .period_tick  (period_tick),
        .busy         (busy)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec = n_vec + 1;
        if (obs != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        if (v < DMIN) return DMIN;
        if (v > DMAX) return DMAX;
        return v;
    endfunction

    // Advance the reference model across one rising edge using the inputs driven before it.
    task automatic model_edge();
        bit tick;
        int d;
        int s;
        int mv;
        if (rst) begin
            m_cnt  = 0;
            m_cmp  = DMIN;
            m_tgt  = DMIN;
            m_busy = 1'b0;
        end else begin
            tick = (m_cnt == PER - 1);
            if (target_valid && !tick) begin
                m_tgt  = clampv(int'(target));
                m_busy = (m_tgt != m_cmp);
            end else if (tick && m_busy) begin
`ifdef SLEW_LIMIT_EN
                d  = (m_tgt > m_cmp) ? (m_tgt - m_cmp) : (m_cmp - m_tgt);
                s  = (step == 8'd0) ? 1 : int'(step);
                mv = (s < d) ? s : d;
                m_cmp = (m_tgt > m_cmp) ? (m_cmp + mv) : (m_cmp - mv);
`else
                d  = 0;
                s  = 0;
                mv = d + s;
                m_cmp = m_tgt + mv;
`endif
                m_busy = (m_cmp != m_tgt);
            end
            m_cnt = (m_cnt + 1) % PER;
        end
    endtask

    task automatic check_outputs();
        chk("compare", int'(compare), m_cmp);
        chk("busy", int'(busy), int'(m_busy));
        chk("period_tick", int'(period_tick), (m_cnt == PER - 1) ? 1 : 0);
        chk("target_ready", int'(target_ready), (!rst && m_cnt != PER - 1) ? 1 : 0);
    endtask

    function automatic int pick_target();
        int r;
        case ($urandom_range(0, 4))
            0: r = 0;
            1: r = 4095;
            2: r = m_cmp;
            3: begin
                r = m_cmp + $urandom_range(0, 60) - 30;
                if (r < 0) r = 0;
                if (r > 4095) r = 4095;
            end
            default: r = $urandom_range(0, 4095);
        endcase
        return r;
    endfunction

    initial begin
        n_vec        = 0;
        n_err        = 0;
        m_cnt        = 0;
        m_cmp        = 0;
        m_tgt        = 0;
        m_busy       = 1'b0;
        rst          = 1'b1;
        target       = 12'd0;
        target_valid = 1'b0;
        step         = 8'd1;

        // Three reset cycles: compare=1, busy=0, target_ready=0 throughout.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
        end
        rst = 1'b0;

        for (int n = 0; n < NCYC; n++) begin
            target_valid = 1'b0;
            rst          = 1'b0;
            if (n == 10) begin
                // Ramp up from the reset value, step 100.
                target = 12'd100; step = 8'd100; target_valid = 1'b1;
            end else if (n == PER + 10) begin
                // 100 -> 400 in steps of 100 when slew limited.
                target = 12'd400; target_valid = 1'b1;
            end else if (n >= 4 * PER + 4094 && n <= 4 * PER + 4096) begin
                // Held across the boundary cycle; also exercises the upper clamp.
                target = 12'd4095; step = 8'd255; target_valid = 1'b1;
            end else if (n == 5 * PER + 100) begin
                // Lower clamp, retargets downward mid-ramp.
                target = 12'd0; target_valid = 1'b1;
            end else if (n == 8 * PER + 100) begin
                target = 12'd3000; step = 8'd10; target_valid = 1'b1;
            end else if (n == 9 * PER + 2000 || n == 9 * PER + 2001) begin
                // Reset while a ramp is in progress.
                rst = 1'b1;
            end else if (n >= 6 * PER && n < 15 * PER && (n < 8 * PER || n >= 10 * PER)
                         && $urandom_range(0, 1499) == 0) begin
                target       = 12'(pick_target());
                target_valid = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    step = 8'd0;
                end else begin
                    step = 8'($urandom_range(1, 255));
                end
            end
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
